ssd_scan_arbiter: RTL and testbench

SSD_SCAN_ARBITER -- requirements
Module: ssd_scan_arbiter

---
 rtl/ssd_scan_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ssd_scan_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_arbiter.sv
// rtl/ssd_scan_arbiter.sv - two-requester seven-segment display scan arbiter
//
// Purpose:
//   Shares one 8-digit multiplexed seven-segment display between two
//   requesters. A free-running prescaler produces a digit-scan tick. An
//   IDLE/OWN_A/OWN_B arbiter hands the display to a requester. The owner
//   keeps it for at least HOLD_TICKS scan ticks. After that the grant moves
//   round-robin, or drops to IDLE when nobody asks. The owner's 32-bit word
//   is latched into a frame buffer on entry and refreshed only at frame
//   boundaries, so a scan never mixes two values.
//
// Ports:
//   clk         in   system clock, all registers on rising edge
//   reset       in   synchronous active-low reset
//   req_a       in   requester A level request (wins ties from IDLE)
//   data_a      in   requester A hex digits, digit k = data_a[4k+3:4k]
//   req_b       in   requester B level request
//   data_b      in   requester B hex digits, same packing
//   grant_a     out  requester A owns the display
//   grant_b     out  requester B owns the display
//   ssdAnode    out  active-low digit enables (registered)
//   ssdCathode  out  active-low segments g..a (registered)
//   digit_sel   out  index of the digit currently being scanned

module ssd_scan_arbiter #(
  parameter int SCAN_DIV   = 12_500,
  parameter int HOLD_TICKS = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [7:0]  ssdAnode,
  output logic [6:0]  ssdCathode,
  output logic [2:0]  digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_e;

  // Active-low seven-segment decode, bit6 = g ... bit0 = a.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_e        state_q,   state_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [2:0]    digit_q,   digit_d;
  logic [HW-1:0] hold_q,    hold_d;
  logic [31:0]   fbuf_q,    fbuf_d;
  logic          grant_a_q, grant_a_d;
  logic          grant_b_q, grant_b_d;
  logic [7:0]    anode_q,   anode_d;
  logic [6:0]    cathode_q, cathode_d;

  logic       tick;
  logic       frame_end;
  logic       hold_done;
  logic       entering;
  logic       owning;
  logic [3:0] cur_nibble;

  assign tick      = (presc_q == PRESC_LAST);
  assign frame_end = tick && (digit_q == 3'd7);
  assign hold_done = (hold_q == HOLD_MAX);

  // Scan timebase: runs regardless of arbitration state.
  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (tick) begin
      presc_d = '0;
      digit_d = digit_q + 3'd1;
    end
  end

  // Arbitration. Once the hold time is served the other requester always
  // wins if it is asking, which gives round-robin under contention.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_a)      state_d = S_OWN_A;
        else if (req_b) state_d = S_OWN_B;
      end
      S_OWN_A: begin
        if (hold_done) begin
          if (req_b)       state_d = S_OWN_B;
          else if (!req_a) state_d = S_IDLE;
        end
      end
      S_OWN_B: begin
        if (hold_done) begin
          if (req_a)       state_d = S_OWN_A;
          else if (!req_b) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entering = (state_d != state_q) && (state_d != S_IDLE);

  // Hold counter and frame buffer. A new owner's data is captured on the
  // entry edge so the very first scanned digit already shows it; after that
  // the buffer only refreshes when digit 7 hands over to digit 0.
  always_comb begin
    hold_d = hold_q;
    fbuf_d = fbuf_q;
    if (entering) begin
      hold_d = '0;
      fbuf_d = (state_d == S_OWN_A) ? data_a : data_b;
    end else if (state_d == S_IDLE) begin
      hold_d = '0;
    end else begin
      if (tick && !hold_done) hold_d = hold_q + HW'(1);
      if (frame_end)          fbuf_d = (state_q == S_OWN_A) ? data_a : data_b;
    end
  end

  // Grants track the state register exactly: decode the next state so the
  // registered grant changes on the same edge as the state.
  always_comb begin
    grant_a_d = (state_d == S_OWN_A);
    grant_b_d = (state_d == S_OWN_B);
  end

  // Display drive, one clock behind digit select and frame buffer.
  assign owning     = (state_q != S_IDLE);
  assign cur_nibble = fbuf_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    anode_d   = 8'hFF;
    cathode_d = 7'h7F;
    if (owning) begin
      anode_d   = ~(8'd1 << digit_q);
      cathode_d = hex_seg(cur_nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      digit_q   <= '0;
      hold_q    <= '0;
      fbuf_q    <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      anode_q   <= 8'hFF;
      cathode_q <= 7'h7F;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      hold_q    <= hold_d;
      fbuf_q    <= fbuf_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign grant_a    = grant_a_q;
  assign grant_b    = grant_b_q;
  assign ssdAnode   = anode_q;
  assign ssdCathode = cathode_q;
  assign digit_sel  = digit_q;

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// tb/tb_ssd_scan_arbiter.sv - self-checking bench for ssd_scan_arbiter

module tb_ssd_scan_arbiter;

  localparam int SD = 4;
  localparam int HT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [31:0] data_a = 32'h0;
  logic [31:0] data_b = 32'h0;
  logic        grant_a, grant_b;
  logic [7:0]  ssdAnode;
  logic [6:0]  ssdCathode;
  logic [2:0]  digit_sel;

  ssd_scan_arbiter #(.SCAN_DIV(SD), .HOLD_TICKS(HT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .data_a     (data_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .ssdAnode   (ssdAnode),
    .ssdCathode (ssdCathode),
    .digit_sel  (digit_sel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment table written straight from the digit shapes.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int          m_presc = 0, m_digit = 0, m_owner = 0, m_hold = 0;
  logic [31:0] m_fb = 32'h0;
  logic [7:0]  m_an = 8'hFF;
  logic [6:0]  m_cat = 7'h7F;
  bit          m_valid = 1'b0;

  initial begin
    int tick, nxt, own_req, oth_req;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_presc = 0; m_digit = 0; m_owner = 0; m_hold = 0;
        m_fb = 32'h0; m_an = 8'hFF; m_cat = 7'h7F;
      end else begin
        tick = (m_presc == SD - 1) ? 1 : 0;
        // displayed digit reflects the situation just before this edge
        if (m_owner != 0) begin
          m_an  = 8'hFF ^ (8'(1) << m_digit);
          m_cat = seg_tab[4'(m_fb >> (4 * m_digit))];
        end else begin
          m_an  = 8'hFF;
          m_cat = 7'h7F;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
          nxt = req_a ? 1 : (req_b ? 2 : 0);
        end else if (m_hold >= HT) begin
          own_req = (m_owner == 1) ? int'(req_a) : int'(req_b);
          oth_req = (m_owner == 1) ? int'(req_b) : int'(req_a);
          if (oth_req != 0)      nxt = 3 - m_owner;
          else if (own_req == 0) nxt = 0;
        end
        if (nxt != 0 && nxt != m_owner) begin
          m_hold = 0;
          m_fb   = (nxt == 1) ? data_a : data_b;
        end else if (nxt != 0) begin
          if (tick != 0 && m_hold < HT) m_hold++;
          if (tick != 0 && m_digit == 7) m_fb = (nxt == 1) ? data_a : data_b;
        end else begin
          m_hold = 0;
        end
        m_owner = nxt;
        if (tick != 0) begin
          m_presc = 0;
          m_digit = (m_digit + 1) % 8;
        end else begin
          m_presc++;
        end
      end
      m_valid = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("grant_a",    32'(grant_a),    32'(m_owner == 1));
        check("grant_b",    32'(grant_b),    32'(m_owner == 2));
        check("mutex",      32'(grant_a & grant_b), 32'h0);
        check("digit_sel",  32'(digit_sel),  32'(m_digit));
        check("ssdAnode",   32'(ssdAnode),   32'(m_an));
        check("ssdCathode", 32'(ssdCathode), 32'(m_cat));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int cnt, prev_d, prev_g, last_own, cur_own, nchg;
  int own_seq [3];
  bit dropped;

  initial begin
    // Reset and idle scan
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    check("rst_grant_a", 32'(grant_a), 32'h0);
    check("rst_grant_b", 32'(grant_b), 32'h0);
    check("rst_anode",   32'(ssdAnode), 32'hFF);
    check("rst_cathode", 32'(ssdCathode), 32'h7F);
    check("rst_digit",   32'(digit_sel), 32'h0);
    step(4);
    check("scan_first_tick", 32'(digit_sel), 32'h1);
    check("idle_anode", 32'(ssdAnode), 32'hFF);
    step(28);
    check("scan_wrap", 32'(digit_sel), 32'h0);

    // Simultaneous requests from IDLE: A wins
    data_a = 32'h76543210;
    data_b = 32'hFEDCBA98;
    req_a = 1'b1;
    req_b = 1'b1;
    step(1);
    check("tie_grant_a", 32'(grant_a), 32'h1);
    check("tie_grant_b", 32'(grant_b), 32'h0);
    for (int i = 0; i < 64 && !(grant_a && ssdAnode == 8'hFE); i++) step(1);
    check("a_dig0_seen", 32'(grant_a && ssdAnode == 8'hFE), 32'h1);
    check("a_dig0_cat",  32'(ssdCathode), 32'b1000000);
    for (int i = 0; i < 64 && !(grant_a && ssdAnode == 8'hF7); i++) step(1);
    check("a_dig3_seen", 32'(grant_a && ssdAnode == 8'hF7), 32'h1);
    check("a_dig3_cat",  32'(ssdCathode), 32'b0110000);

    // Continuous contention: alternate B, A, B with 8 ticks each
    last_own = grant_a ? 1 : (grant_b ? 2 : 0);
    nchg = 0;
    cnt = 0;
    for (int i = 0; i < 400 && nchg < 3; i++) begin
      prev_d = digit_sel;
      step(1);
      cur_own = grant_a ? 1 : (grant_b ? 2 : 0);
      if (cur_own != last_own) begin
        own_seq[nchg] = cur_own;
        if (nchg == 2) check("alt_hold_ticks", 32'(cnt), 32'd8);
        nchg++;
        cnt = 0;
      end else if (digit_sel != 3'(prev_d)) begin
        cnt++;
      end
      last_own = cur_own;
    end
    check("alt_changes", 32'(nchg), 32'd3);
    check("alt_first",  32'(own_seq[0]), 32'd2);
    check("alt_second", 32'(own_seq[1]), 32'd1);
    check("alt_third",  32'(own_seq[2]), 32'd2);

    // Owner drops early: grant must hold for the full 8 ticks
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    step(1);
    reset = 1'b1;
    req_a = 1'b1;
    for (int i = 0; i < 10 && !grant_a; i++) step(1);
    check("hold_grant_a", 32'(grant_a), 32'h1);
    cnt = 0;
    dropped = 1'b0;
    for (int i = 0; i < 200 && !grant_b; i++) begin
      prev_d = digit_sel;
      prev_g = grant_a;
      step(1);
      if (prev_g != 0 && grant_a && digit_sel != 3'(prev_d)) cnt++;
      if (cnt == 3 && !dropped) begin
        req_a = 1'b0;
        req_b = 1'b1;
        dropped = 1'b1;
      end
    end
    check("hold_ticks_a", 32'(cnt), 32'd8);
    check("hold_then_b", 32'(grant_b), 32'h1);
    check("hold_a_off",  32'(grant_a), 32'h0);
    req_b = 1'b0;
    for (int i = 0; i < 200 && grant_b; i++) step(1);
    check("idle_after_hold_b", 32'(grant_b), 32'h0);
    check("idle_after_hold_a", 32'(grant_a), 32'h0);
    step(1);
    check("idle_blank_an",  32'(ssdAnode), 32'hFF);
    check("idle_blank_cat", 32'(ssdCathode), 32'h7F);

    // Mid-frame data change: rest of frame keeps old nibbles
    data_a = 32'h76543210;
    req_a = 1'b1;
    for (int i = 0; i < 80 && !(grant_a && digit_sel == 3'd3); i++) step(1);
    check("tear_at_dig3", 32'(grant_a && digit_sel == 3'd3), 32'h1);
    data_a = 32'h89ABCDEF;
    for (int i = 0; i < 40 && ssdAnode != 8'hDF; i++) step(1);
    check("tear_old_dig5", 32'(ssdCathode), 32'b0010010);
    for (int i = 0; i < 40 && digit_sel != 3'd0; i++) step(1);
    for (int i = 0; i < 40 && ssdAnode != 8'hDF; i++) step(1);
    check("tear_new_dig5", 32'(ssdCathode), 32'b0001000);

    // Reset pulse while B owns
    req_a = 1'b0;
    req_b = 1'b1;
    for (int i = 0; i < 300 && !grant_b; i++) step(1);
    check("rst_mid_own_b", 32'(grant_b), 32'h1);
    step(2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("rst_mid_grant_b", 32'(grant_b), 32'h0);
    check("rst_mid_anode",   32'(ssdAnode), 32'hFF);
    check("rst_mid_digit",   32'(digit_sel), 32'h0);
    step(1);
    check("rst_regrant_b", 32'(grant_b), 32'h1);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) req_a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) req_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) data_a = $urandom;
      if ($urandom_range(0, 4) == 0) data_b = $urandom;
      reset = ($urandom_range(0, 399) != 0);
      step(1);
    end
    reset = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
